// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a word-addressed register memory.
// Adds programmable wait states, error responses for out-of-range,
// misaligned, read-only and strobed-read accesses, and a saturating
// count of error completions. All outputs come straight from flops.
module apb_slave_mem #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        DEPTH     = 64,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = {ADDR_W{1'b0}},
    parameter int unsigned        MAX_WAIT  = 15,
    parameter int unsigned        RO_WORDS  = 0,
    localparam int unsigned       WAIT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W/8-1:0]   PSTRB,
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [WAIT_W-1:0]     wait_cfg,
    output logic [15:0]           err_cnt,
    output logic                  busy
);

    localparam int unsigned         BYTES      = DATA_W / 8;
    localparam int unsigned         LSB_W      = $clog2(BYTES);
    localparam int unsigned         IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0]   SPAN       = ADDR_W'(DEPTH * BYTES);
    localparam logic [ADDR_W-1:0]   ALIGN_MASK = ADDR_W'(BYTES - 1);
    localparam logic [IDX_W:0]      RO_LIM     = (IDX_W + 1)'(RO_WORDS);
    localparam logic [WAIT_W-1:0]   MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WAIT_W-1:0]    r_cnt;
    logic                 r_ready;
    logic                 r_slverr;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_busy;
    logic [15:0]          r_err_cnt;
    logic                 r_write;
    logic                 r_err;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_W-1:0]    r_wdata;
    logic [BYTES-1:0]     r_strb;
    logic [DATA_W-1:0]    r_mem [DEPTH];

    logic [ADDR_W:0]      w_diff;
    logic [ADDR_W-1:0]    w_off;
    logic                 w_below;
    logic                 w_above;
    logic                 w_misalign;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_ro_hit;
    logic                 w_err;
    logic [WAIT_W-1:0]    w_wait;
    logic                 w_wait_zero;
    logic                 w_setup;
    logic                 w_access;
    logic [DATA_W-1:0]    w_setup_rdata;
    logic [DATA_W-1:0]    w_acc_rdata;
    logic                 w_load;
    logic [WAIT_W-1:0]    w_cnt_nxt;
    logic                 w_ready_nxt;
    logic                 w_slverr_nxt;
    logic [DATA_W-1:0]    w_rdata_nxt;
    logic                 w_commit;
    logic                 w_err_inc;

    // Address decode: the borrow of PADDR-BASE_ADDR flags addresses below the window.
    assign w_diff     = {1'b0, PADDR} - {1'b0, BASE_ADDR};
    assign w_below    = w_diff[ADDR_W];
    assign w_off      = w_diff[ADDR_W-1:0];
    assign w_above    = !w_below && (w_off >= SPAN);
    assign w_misalign = (PADDR & ALIGN_MASK) != {ADDR_W{1'b0}};
    assign w_idx      = IDX_W'(w_off >> LSB_W);
    assign w_ro_hit   = ({1'b0, w_idx} + (IDX_W + 1)'(1'b1)) <= RO_LIM;
    assign w_err      = w_below || w_above || w_misalign ||
                        (PWRITE && w_ro_hit) ||
                        (!PWRITE && (PSTRB != {BYTES{1'b0}}));

    // Out-of-range wait requests saturate at the largest supported count.
    assign w_wait      = ({1'b0, wait_cfg} > {1'b0, MAX_WAIT_C}) ? MAX_WAIT_C : wait_cfg;
    assign w_wait_zero = (w_wait == {WAIT_W{1'b0}});

    assign w_setup  = PSEL && !PENABLE;
    assign w_access = PSEL && PENABLE;

    // Errored or write transfers always return zero read data.
    assign w_setup_rdata = (!PWRITE && !w_err) ? r_mem[w_idx] : {DATA_W{1'b0}};
    assign w_acc_rdata   = (!r_write && !r_err) ? r_mem[r_idx] : {DATA_W{1'b0}};

    // Next-state and next-output decode for the IDLE/ACCESS controller.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_cnt_nxt    = r_cnt;
        w_ready_nxt  = 1'b0;
        w_slverr_nxt = 1'b0;
        w_rdata_nxt  = {DATA_W{1'b0}};
        w_commit     = 1'b0;
        w_err_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_state_nxt  = ST_ACCESS;
                    w_load       = 1'b1;
                    w_cnt_nxt    = w_wait;
                    w_ready_nxt  = w_wait_zero;
                    w_slverr_nxt = w_wait_zero && w_err;
                    w_rdata_nxt  = w_wait_zero ? w_setup_rdata : {DATA_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (w_access && r_ready) begin
                    // Completion: commit and count, then drop all responses.
                    w_state_nxt = ST_IDLE;
                    w_commit    = r_write && !r_err;
                    w_err_inc   = r_err;
                end else if (w_access) begin
                    w_cnt_nxt = r_cnt - WAIT_W'(1'b1);
                    if (r_cnt == WAIT_W'(1'b1)) begin
                        w_ready_nxt  = 1'b1;
                        w_slverr_nxt = r_err;
                        w_rdata_nxt  = w_acc_rdata;
                    end else begin
                        w_ready_nxt = 1'b0;
                    end
                end else if (w_setup) begin
                    // Setup seen mid-transfer: drop the old transfer, start the new one.
                    w_state_nxt  = ST_ACCESS;
                    w_load       = 1'b1;
                    w_cnt_nxt    = w_wait;
                    w_ready_nxt  = w_wait_zero;
                    w_slverr_nxt = w_wait_zero && w_err;
                    w_rdata_nxt  = w_wait_zero ? w_setup_rdata : {DATA_W{1'b0}};
                end else begin
                    // PSEL dropped before completion: abort silently.
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs, wait counter, latched transfer attributes and error counter.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_cnt     <= {WAIT_W{1'b0}};
            r_ready   <= 1'b0;
            r_slverr  <= 1'b0;
            r_rdata   <= {DATA_W{1'b0}};
            r_busy    <= 1'b0;
            r_err_cnt <= 16'h0000;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_idx     <= {IDX_W{1'b0}};
            r_wdata   <= {DATA_W{1'b0}};
            r_strb    <= {BYTES{1'b0}};
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_ready  <= w_ready_nxt;
            r_slverr <= w_slverr_nxt;
            r_rdata  <= w_rdata_nxt;
            r_busy   <= (w_state_nxt == ST_ACCESS);
            if (w_load) begin
                r_write <= PWRITE;
                r_err   <= w_err;
                r_idx   <= w_idx;
                r_wdata <= PWDATA;
                r_strb  <= PSTRB;
            end
            if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    // Memory array: cleared by reset, byte-lane write at transfer completion.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (w_commit) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (r_strb[b]) begin
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign PRDATA  = r_rdata;
    assign PREADY  = r_ready;
    assign PSLVERR = r_slverr;
    assign err_cnt = r_err_cnt;
    assign busy    = r_busy;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: directed scenarios plus random
// back-to-back traffic against a behavioural memory/error model.
module tb_apb_slave_mem;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned MAXW  = 10;
    localparam int unsigned RO    = 2;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        ACLK     = 1'b0;
    logic        ARESETn  = 1'b0;
    logic        PSEL     = 1'b0;
    logic        PENABLE  = 1'b0;
    logic        PWRITE   = 1'b0;
    logic [31:0] PADDR    = 32'h0;
    logic [31:0] PWDATA   = 32'h0;
    logic [3:0]  PSTRB    = 4'h0;
    logic [3:0]  wait_cfg = 4'h0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [15:0] err_cnt;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [DEPTH];
    int unsigned model_errs;

    apb_slave_mem #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .MAX_WAIT  (MAXW),
        .RO_WORDS  (RO)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .wait_cfg (wait_cfg),
        .err_cnt  (err_cnt),
        .busy     (busy)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt();
        return (model_errs > 32'd65535) ? 16'hFFFF : 16'(model_errs);
    endfunction

    function automatic bit model_err(input bit wr, input logic [31:0] addr, input logic [3:0] strb);
        if (addr < BASE || addr >= BASE + DEPTH * 4) return 1'b1;
        if (addr % 4 != 0) return 1'b1;
        if (wr && ((addr - BASE) / 4) < RO) return 1'b1;
        if (!wr && strb != 4'h0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        model_errs = 0;
    endtask

    // One full transfer; PSEL/PENABLE are left high after the completion edge
    // so the next call can follow back-to-back.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int cfg, input string tag);
        int          exp_wait;
        int          k;
        bit          e;
        bit          done;
        int          idx;
        logic [31:0] exp_rd;
        exp_wait = (cfg > int'(MAXW)) ? int'(MAXW) : cfg;
        e        = model_err(wr, addr, strb);
        idx      = e ? 0 : int'((addr - BASE) / 4);
        exp_rd   = (wr || e) ? 32'h0 : model_mem[idx];
        @(negedge ACLK);
        check({tag, " idle_outputs"}, {PREADY, PSLVERR, busy, PRDATA}, 35'h0);
        check({tag, " err_cnt"}, err_cnt, exp_cnt());
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
        PWDATA = wdata; PSTRB = strb; wait_cfg = 4'(cfg);
        @(posedge ACLK);
        @(negedge ACLK);
        PENABLE = 1'b1;
        k = 1;
        done = 1'b0;
        while (!done && k <= int'(MAXW) + 4) begin
            if (PREADY) begin
                done = 1'b1;
            end else begin
                wait_cfg = 4'($urandom);
                @(posedge ACLK);
                @(negedge ACLK);
                k++;
            end
        end
        check({tag, " ready_cycle"}, k, exp_wait + 1);
        check({tag, " busy"}, busy, 1'b1);
        if (done) begin
            check({tag, " pslverr"}, PSLVERR, e);
            check({tag, " prdata"}, PRDATA, exp_rd);
            @(posedge ACLK);
        end
        if (e) begin
            model_errs++;
        end else if (wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
    endtask

    task automatic go_idle();
        @(negedge ACLK);
        PSEL = 1'b0;
        PENABLE = 1'b0;
    endtask

    // Start a write and drop out of it after two access cycles.
    task automatic start_and_stall(input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge ACLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr;
        PWDATA = wdata; PSTRB = 4'hF; wait_cfg = 4'd5;
        @(posedge ACLK);
        @(negedge ACLK);
        PENABLE = 1'b1;
        check("stall access1", {busy, PREADY}, 2'b10);
        @(posedge ACLK);
        @(negedge ACLK);
        check("stall access2", {busy, PREADY}, 2'b10);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        bit          w;
        int          r;

        model_reset();

        // Reset state
        repeat (3) @(negedge ACLK);
        check("reset outputs", {PREADY, PSLVERR, busy, PRDATA, err_cnt}, 51'h0);
        ARESETn = 1'b1;

        // 1: every word reads zero after reset, zero waits
        for (int i = 0; i < DEPTH; i++) xfer(1'b0, BASE + 32'(i * 4), 32'h0, 4'h0, 0, "t1 read");

        // 2: strobed write with three wait states, then readback
        xfer(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'b0101, 3, "t2 write");
        xfer(1'b0, BASE + 32'h10, 32'h0, 4'h0, 3, "t2 read");
        go_idle();
        @(negedge ACLK);
        check("t2 value", model_mem[4], 32'h00AD00EF);

        // 3: out-of-range, misaligned, strobed read, below-base
        xfer(1'b0, BASE + DEPTH * 4, 32'h0, 4'h0, 0, "t3 range");
        xfer(1'b1, BASE + 32'h2, 32'hFFFFFFFF, 4'hF, 0, "t3 misalign");
        xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 0, "t3 rdstrb");
        go_idle();
        @(negedge ACLK);
        check("t3 err_cnt", err_cnt, 16'd3);
        xfer(1'b0, BASE - 32'h4, 32'h0, 4'h0, 1, "t3 below");
        xfer(1'b0, BASE, 32'h0, 4'h0, 0, "t3 word0");
        xfer(1'b0, BASE + 32'h10, 32'h0, 4'h0, 0, "t3 word4");

        // 4: read-only bottom words
        xfer(1'b1, BASE + 32'h4, 32'h1234, 4'hF, 0, "t4 ro write");
        xfer(1'b0, BASE + 32'h4, 32'h0, 4'h0, 0, "t4 ro read");
        xfer(1'b1, BASE + 32'h8, 32'h1234, 4'hF, 2, "t4 rw write");
        xfer(1'b0, BASE + 32'h8, 32'h0, 4'h0, 0, "t4 rw read");
        xfer(1'b1, BASE + 32'h8, 32'hFFFFFFFF, 4'h0, 0, "t4 zero strb");
        xfer(1'b0, BASE + 32'h8, 32'h0, 4'h0, 12, "t4 clamp");
        go_idle();

        // 5a: abort by dropping PSEL
        start_and_stall(BASE + 32'h14, 32'hA5A5A5A5);
        PSEL = 1'b0;
        PENABLE = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        check("abort idle", {busy, PREADY, PSLVERR}, 3'b000);
        xfer(1'b0, BASE + 32'h14, 32'h0, 4'h0, 0, "t5 after abort");
        go_idle();

        // 5b: asynchronous reset mid-transfer
        start_and_stall(BASE + 32'h18, 32'h5A5A5A5A);
        ARESETn = 1'b0;
        #1;
        check("reset mid outputs", {PREADY, PSLVERR, busy, PRDATA, err_cnt}, 51'h0);
        PSEL = 1'b0;
        PENABLE = 1'b0;
        model_reset();
        @(negedge ACLK);
        ARESETn = 1'b1;
        for (int i = 0; i < DEPTH; i += 2) xfer(1'b0, BASE + 32'(i * 4), 32'h0, 4'h0, 0, "t5 cleared");

        // 6: random back-to-back traffic
        for (int n = 0; n < 100; n++) begin
            w = 1'($urandom);
            a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            s = w ? 4'($urandom) : 4'h0;
            r = int'($urandom_range(0, 7));
            if (r == 0) a = a + 32'($urandom_range(1, 3));
            else if (r == 1) a = BASE + DEPTH * 4 + 32'($urandom_range(0, 15) * 4);
            else if (r == 2 && !w) s = 4'($urandom_range(1, 15));
            xfer(w, a, $urandom, s, int'($urandom_range(0, 15)), "t6 rand");
        end
        for (int i = 0; i < DEPTH; i++) xfer(1'b0, BASE + 32'(i * 4), 32'h0, 4'h0, 0, "t6 sweep");

        // 6: error counter saturation
        for (int n = 0; n < 65540; n++) xfer(1'b0, BASE + DEPTH * 4, 32'h0, 4'h0, 0, "t6 sat");
        go_idle();
        @(negedge ACLK);
        check("sat err_cnt", err_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- Parametrised APB4 completer (slave) for the NoC subsystem: a word-addressed register memory with per-byte write strobes.
- Adds the following to the fixed 32-bit APB slave channel: programmable wait states, address/alignment/read-only error responses, and a saturating error counter.
- One instance sits behind each APB slave port of the NoC bridge.
- Serves as the synthesizable endpoint for the S0..Sn slave channels in block and system benches.

Parameters:
- ADDR_W, 32, PADDR width.
- DATA_W, 32, PWDATA/PRDATA width; legal values are 8, 16, 32, 64.
- DEPTH, 64, number of DATA_W-bit words in the memory.
- BASE_ADDR, 0, byte address of word 0; must be aligned to DATA_W/8.
- MAX_WAIT, 15, largest programmable wait-state count.
- RO_WORDS, 0, number of read-only words at the bottom of the map (words 0..RO_WORDS-1).

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  byte write strobes.
- PRDATA  out  DATA_W  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response.
- wait_cfg  in  $clog2(MAX_WAIT+1)  wait states applied to the next transfer; values above MAX_WAIT are clamped to MAX_WAIT.
- err_cnt  out  16  count of PSLVERR responses, saturating.
- busy  out  1  high while the FSM is in ACCESS.

Behaviour:
- Reset (ARESETn=0, asynchronous):
  - FSM goes to IDLE; memory clears to 0.
  - PRDATA=0, PREADY=0, PSLVERR=0, err_cnt=0, busy=0.
  - Reset asserted mid-transfer aborts the transfer; no memory update occurs.
- FSM states IDLE and ACCESS. All outputs are registered.
- IDLE:
  - Setup phase is detected when PSEL=1 and PENABLE=0.
  - On that edge, latch PADDR, PWRITE, PWDATA, PSTRB, and the clamped wait_cfg into cnt; evaluate the error flag; move to ACCESS.
  - If cnt==0, also set PREADY=1 on the same edge.
- ACCESS:
  - busy=1.
  - Each edge with PSEL=1 and PENABLE=1 and cnt>0 decrements cnt.
  - PREADY rises on the edge where cnt becomes 0, so the transfer completes in exactly N+1 access cycles for N wait states.
- Completion cycle (PREADY=1 sampled with PSEL=1 and PENABLE=1):
  - The write commits at the end of this cycle.
  - Next edge: PREADY=0, PSLVERR=0, PRDATA=0, return to IDLE.
  - A new setup phase may follow immediately: two-cycle back-to-back transfers are supported.
- Error flag: set when any of the following holds.
  - PADDR < BASE_ADDR, or PADDR >= BASE_ADDR + DEPTH*DATA_W/8.
  - PADDR[log2(DATA_W/8)-1:0] is nonzero (misaligned).
  - Write to word index < RO_WORDS.
  - Read with PSTRB nonzero.
- Error response:
  - PSLVERR is driven only while PREADY=1 and is otherwise 0.
  - An errored write leaves memory unchanged; an errored read returns PRDATA=0.
  - err_cnt increments once per errored completion and holds at 0xFFFF.
- Writes: byte lane i of the addressed word updates only if PSTRB[i]=1. A write with PSTRB=0 is legal: no change, no error.
- Reads: PRDATA = mem[index], valid only while PREADY=1; 0 at all other times.
- Abort: PSEL=0 seen in ACCESS before completion:
  - Return to IDLE; no write; no PREADY; no error count.
- Protocol violation: PENABLE=0 with PSEL=1 while in ACCESS is treated as abort followed by a new setup phase.
- wait_cfg changes during ACCESS do not affect the transfer in flight.

Test Plan:
1. Reset, then read every word with wait_cfg=0 → PRDATA=0, PREADY in the 1st access cycle, PSLVERR=0, err_cnt=0.
2. Write 0xDEADBEEF to BASE+0x10 with PSTRB=4'b0101, then read it back → readback 0x00AD00EF. With wait_cfg=3, PREADY rises in the 4th access cycle of each transfer.
3. Read BASE+DEPTH*4, write BASE+0x2 (misaligned), and read with PSTRB=4'hF → three completions with PSLVERR=1 and PRDATA=0, memory unchanged, err_cnt=3.
4. RO_WORDS=2: write 0x1234 to word 1 → PSLVERR=1, readback 0. Write 0x1234 to word 2 → OK, readback 0x1234.
5. Start a write with wait_cfg=5, deassert PSEL after 2 access cycles → no PREADY, memory unchanged. Repeat with ARESETn pulsed mid-ACCESS → all outputs 0 immediately, memory 0.
6. Run 100 back-to-back random transfers with a reference model, plus 65540 errored reads → data matches the model; err_cnt saturates at 0xFFFF.
